// File: rtl/psum_acc_sched_pkg.sv
// Shared types and constants for the partial-sum accumulate scheduler.
// PSUM_SAT_EN selects saturating lane adds (see psum_lane_acc).
package psum_acc_sched_pkg;

  localparam int unsigned LANES = 10;
  localparam int unsigned DW    = 20;
  localparam int unsigned CW    = 8;
  localparam int unsigned BW    = LANES * DW;

  typedef logic signed [DW-1:0] lane_t;

  // Lane 0 occupies the least significant bits.
  typedef struct packed {
    lane_t [LANES-1:0] lane;
  } psum_bus_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam lane_t PSUM_MAX = {1'b0, {(DW-1){1'b1}}};
  localparam lane_t PSUM_MIN = {1'b1, {(DW-1){1'b0}}};

  // Clamp a DW+1 bit signed sum to the lane range.
  function automatic lane_t sat_clip(input logic [DW:0] wide);
    if (wide[DW] == wide[DW-1]) return lane_t'(wide[DW-1:0]);
    else if (wide[DW])          return PSUM_MIN;
    else                        return PSUM_MAX;
  endfunction

endpackage

// File: rtl/psum_acc_sched_if.sv
// PE-side and writer-side valid/ready channels of the partial-sum scheduler.
interface psum_acc_sched_if;
  import psum_acc_sched_pkg::*;

  logic      pe_valid;
  logic      pe_ready;
  psum_bus_t pe_data;
  logic      out_valid;
  logic      out_ready;
  psum_bus_t out_data;

  // master: the scheduler; slave: the PE array and writer around it
  modport master (
    input  pe_valid, pe_data, out_ready,
    output pe_ready, out_valid, out_data
  );

  modport slave (
    output pe_valid, pe_data, out_ready,
    input  pe_ready, out_valid, out_data
  );

endinterface

// File: rtl/psum_lane_acc.sv
// One partial-sum lane: load or accumulate; wraps, or saturates when PSUM_SAT_EN is defined.
module psum_lane_acc
  import psum_acc_sched_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  acc,
  input  lane_t din,
  output lane_t q
`ifdef PSUM_SAT_EN
  ,
  output logic  clip_c
`endif
);

  lane_t sum_c;

`ifdef PSUM_SAT_EN
  logic [DW:0] wide_c;

  always_comb begin
    wide_c = {q[DW-1], q} + {din[DW-1], din};
    clip_c = wide_c[DW] ^ wide_c[DW-1];
    sum_c  = sat_clip(wide_c);
  end
`else
  always_comb begin
    sum_c = q + din;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= din;
    else if (acc)  q <= sum_c;
  end

endmodule

// File: rtl/psum_acc_sched.sv
// Tile accumulation scheduler: passes per tile, drain over valid/ready, done after last tile.
// Optional PSUM_SAT_EN: saturating lanes plus sticky sat_flag port.
module psum_acc_sched
  import psum_acc_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CW-1:0]     num_pass,
  input  logic [CW-1:0]     num_tile,
  psum_acc_sched_if.master  io,
  output logic              busy,
  output logic              done
`ifdef PSUM_SAT_EN
  ,
  output logic              sat_flag
`endif
);

  state_e        state, state_n;
  logic [CW-1:0] pass_cnt, pass_n;
  logic [CW-1:0] tile_cnt, tile_n;
  logic [CW-1:0] np, np_n;
  logic [CW-1:0] nt, nt_n;
  logic          load_c, acc_c;
  lane_t         lane_q [LANES];

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      pass_cnt <= '0;
      tile_cnt <= '0;
      np       <= '0;
      nt       <= '0;
    end else begin
      state    <= state_n;
      pass_cnt <= pass_n;
      tile_cnt <= tile_n;
      np       <= np_n;
      nt       <= nt_n;
    end
  end

  // Next-state, counters and lane enables.
  always_comb begin
    state_n = state;
    pass_n  = pass_cnt;
    tile_n  = tile_cnt;
    np_n    = np;
    nt_n    = nt;
    load_c  = 1'b0;
    acc_c   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          np_n    = (num_pass == '0) ? CW'(1) : num_pass;
          nt_n    = (num_tile == '0) ? CW'(1) : num_tile;
          pass_n  = '0;
          tile_n  = '0;
          state_n = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (io.pe_valid) begin
          load_c = (pass_cnt == '0);
          acc_c  = (pass_cnt != '0);
          if (pass_cnt == np - CW'(1)) begin
            pass_n  = '0;
            state_n = ST_DRAIN;
          end else begin
            pass_n = pass_cnt + CW'(1);
          end
        end
      end
      ST_DRAIN: begin
        if (io.out_ready) begin
          if (tile_cnt == nt - CW'(1)) begin
            tile_n  = '0;
            state_n = ST_DONE;
          end else begin
            tile_n  = tile_cnt + CW'(1);
            state_n = ST_ACCUM;
          end
        end
      end
      ST_DONE:  state_n = ST_IDLE;
      default:  state_n = ST_IDLE;
    endcase
  end

  // Handshake and status are pure decodes of the state register.
  assign io.pe_ready  = (state == ST_ACCUM);
  assign io.out_valid = (state == ST_DRAIN);
  assign busy         = (state != ST_IDLE);
  assign done         = (state == ST_DONE);

`ifdef PSUM_SAT_EN
  logic [LANES-1:0] clip_c;
`endif

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    psum_lane_acc u_lane (
      .clk    (clk),
      .rst    (rst),
      .load   (load_c),
      .acc    (acc_c),
      .din    (io.pe_data.lane[i]),
      .q      (lane_q[i])
`ifdef PSUM_SAT_EN
      ,
      .clip_c (clip_c[i])
`endif
    );
  end

  always_comb begin
    io.out_data = '0;
    for (int i = 0; i < LANES; i++) io.out_data.lane[i] = lane_q[i];
  end

`ifdef PSUM_SAT_EN
  // Sticky per tile: the load beat starts a fresh tile.
  always_ff @(posedge clk) begin
    if (rst)                  sat_flag <= 1'b0;
    else if (load_c)          sat_flag <= 1'b0;
    else if (acc_c && |clip_c) sat_flag <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_psum_acc_sched.sv
// Directed self-checking bench for psum_acc_sched (wrap or PSUM_SAT_EN build).
module tb_psum_acc_sched;
  import psum_acc_sched_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [CW-1:0] num_pass;
  logic [CW-1:0] num_tile;
  logic          busy;
  logic          done;
`ifdef PSUM_SAT_EN
  logic          sat_flag;
`endif

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [BW-1:0] ONE  = BW'(1);
  localparam logic [BW-1:0] ZERO = '0;

  psum_acc_sched_if io ();

  psum_acc_sched dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .num_pass (num_pass),
    .num_tile (num_tile),
    .io       (io.master),
    .busy     (busy),
    .done     (done)
`ifdef PSUM_SAT_EN
    ,
    .sat_flag (sat_flag)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [BW-1:0] got, input logic [BW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic psum_bus_t rep(input lane_t v);
    psum_bus_t r;
    for (int i = 0; i < LANES; i++) r.lane[i] = v;
    return r;
  endfunction

  function automatic psum_bus_t l0(input lane_t v);
    psum_bus_t r;
    r = '0;
    r.lane[0] = v;
    return r;
  endfunction

  task automatic go(input int np_v, input int nt_v);
    num_pass = CW'(np_v);
    num_tile = CW'(nt_v);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  psum_bus_t exp5;

  initial begin
    rst = 1'b1; start = 1'b0; num_pass = '0; num_tile = '0;
    io.pe_valid = 1'b0; io.pe_data = '0; io.out_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // reset state
    check("rst_pe_ready", BW'(io.pe_ready), ZERO);
    check("rst_out_valid", BW'(io.out_valid), ZERO);
    check("rst_busy", BW'(busy), ZERO);
    check("rst_done", BW'(done), ZERO);
    check("rst_out_data", io.out_data, ZERO);

    // 1: basic job, 3 passes 5 + 7 - 2
    go(3, 1);
    check("t1_pe_ready", BW'(io.pe_ready), ONE);
    check("t1_busy", BW'(busy), ONE);
    io.pe_valid = 1'b1;
    io.pe_data = rep(20'sd5);  tick();
    io.pe_data = rep(20'sd7);  tick();
    check("t1_no_valid_early", BW'(io.out_valid), ZERO);
    io.pe_data = rep(-20'sd2); tick();
    io.pe_valid = 1'b0;
    check("t1_out_valid", BW'(io.out_valid), ONE);
    check("t1_pe_ready_drain", BW'(io.pe_ready), ZERO);
    check("t1_out_data", io.out_data, rep(20'sd10));
`ifdef PSUM_SAT_EN
    check("t1_sat_flag", BW'(sat_flag), ZERO);
`endif
    io.out_ready = 1'b1; tick(); io.out_ready = 1'b0;
    check("t1_done", BW'(done), ONE);
    check("t1_busy_done", BW'(busy), ONE);
    tick();
    check("t1_done_pulse", BW'(done), ZERO);
    check("t1_busy_idle", BW'(busy), ZERO);

    // 2: backpressure with pe_valid held through drain
    go(2, 2);
    io.pe_valid = 1'b1;
    io.pe_data = rep(20'sd1); tick();
    io.pe_data = rep(20'sd2); tick();
    io.pe_data = rep(20'sd100);
    for (int k = 0; k < 4; k++) begin
      check("t2_pe_ready_bp", BW'(io.pe_ready), ZERO);
      check("t2_out_data_bp", io.out_data, rep(20'sd3));
      tick();
    end
    io.out_ready = 1'b1; tick(); io.out_ready = 1'b0;
    check("t2_pe_ready_next", BW'(io.pe_ready), ONE);
    check("t2_no_done", BW'(done), ZERO);
    tick();
    io.pe_data = rep(20'sd4); tick();
    io.pe_valid = 1'b0;
    check("t2_tile2_data", io.out_data, rep(20'sd104));
    io.out_ready = 1'b1; tick(); io.out_ready = 1'b0;
    check("t2_done", BW'(done), ONE);
    tick();

    // 3: multi-tile, one pass each, no carry-over
    go(1, 3);
    for (int k = 1; k <= 3; k++) begin
      io.pe_valid = 1'b1; io.pe_data = l0(lane_t'(k)); tick();
      io.pe_valid = 1'b0;
      check("t3_out_valid", BW'(io.out_valid), ONE);
      check("t3_lane0", io.out_data, l0(lane_t'(k)));
      io.out_ready = 1'b1; tick(); io.out_ready = 1'b0;
      check("t3_done", BW'(done), (k == 3) ? ONE : ZERO);
    end
    tick();
    check("t3_single_done", BW'(done), ZERO);

    // 4: zero config behaves as 1/1
    go(0, 0);
    io.pe_valid = 1'b1; io.pe_data = rep(-20'sd3); tick();
    io.pe_valid = 1'b0;
    check("t4_out_valid", BW'(io.out_valid), ONE);
    check("t4_out_data", io.out_data, rep(-20'sd3));
    io.out_ready = 1'b1; tick(); io.out_ready = 1'b0;
    check("t4_done", BW'(done), ONE);
    tick();

    // 5: overflow, lane0 max+1 and lane1 min-1
    go(2, 1);
    io.pe_valid = 1'b1;
    io.pe_data = '0; io.pe_data.lane[0] = 20'sh7FFFF; io.pe_data.lane[1] = 20'sh80000; tick();
    io.pe_data = '0; io.pe_data.lane[0] = 20'sh00001; io.pe_data.lane[1] = 20'shFFFFF; tick();
    io.pe_valid = 1'b0;
    exp5 = '0;
`ifdef PSUM_SAT_EN
    exp5.lane[0] = 20'sh7FFFF; exp5.lane[1] = 20'sh80000;
    check("t5_sat_flag", BW'(sat_flag), ONE);
`else
    exp5.lane[0] = 20'sh80000; exp5.lane[1] = 20'sh7FFFF;
`endif
    check("t5_overflow", io.out_data, exp5);
    io.out_ready = 1'b1; tick(); io.out_ready = 1'b0;
    check("t5_done", BW'(done), ONE);
    tick();

    // 6: reset mid-job aborts, then start ignored while busy
    go(3, 1);
    io.pe_valid = 1'b1; io.pe_data = rep(20'sd9); tick();
    io.pe_valid = 1'b0;
    rst = 1'b1; tick(); rst = 1'b0;
    check("t6_rst_busy", BW'(busy), ZERO);
    check("t6_rst_pe_ready", BW'(io.pe_ready), ZERO);
    check("t6_rst_out_valid", BW'(io.out_valid), ZERO);
    check("t6_rst_out_data", io.out_data, ZERO);
    check("t6_rst_done", BW'(done), ZERO);
    tick();
    check("t6_no_done_after", BW'(done), ZERO);
`ifdef PSUM_SAT_EN
    check("t6_rst_sat_flag", BW'(sat_flag), ZERO);
`endif
    rst = 1'b1; start = 1'b1; num_pass = CW'(1); num_tile = CW'(1); tick();
    rst = 1'b0; start = 1'b0;
    check("t6_rst_beats_start", BW'(busy), ZERO);
    go(2, 1);
    io.pe_valid = 1'b1; io.pe_data = rep(20'sd1); tick();
    start = 1'b1; num_pass = CW'(5); num_tile = CW'(4);
    io.pe_data = rep(20'sd2); tick();
    io.pe_valid = 1'b0;
    check("t6_start_ignored_accum", BW'(io.out_valid), ONE);
    tick();
    start = 1'b0;
    check("t6_start_ignored_drain", BW'(io.out_valid), ONE);
    check("t6_data", io.out_data, rep(20'sd3));
    io.out_ready = 1'b1; tick(); io.out_ready = 1'b0;
    check("t6_done", BW'(done), ONE);
    tick();
    check("t6_idle", BW'(busy), ZERO);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
